// File: rtl/adc_sample_scheduler_if.sv
// Control/status bundle between the ADC sample scheduler and its front-end drivers.
// master = scheduler side; slave = ADC drivers plus configuration and readback.
interface adc_sample_scheduler_if #(
  parameter int unsigned FCNT_W = 16
);
  logic              i_en;
  logic [31:0]       i_m_cyc_t;
  logic [7:0]        i_s_ratio;
  logic              i_clr_err;
  logic              o_m_start;
  logic              i_m_done;
  logic              o_s_start;
  logic              i_s_done;
  logic              o_frame_valid;
  logic              o_frame_sub;
  logic [FCNT_W-1:0] o_frame_cnt;
  logic              o_m_overrun;
  logic              o_timeout;
  logic [1:0]        o_state;

  modport master (
    input  i_en, i_m_cyc_t, i_s_ratio, i_clr_err, i_m_done, i_s_done,
    output o_m_start, o_s_start, o_frame_valid, o_frame_sub, o_frame_cnt,
           o_m_overrun, o_timeout, o_state
  );

  modport slave (
    output i_en, i_m_cyc_t, i_s_ratio, i_clr_err, i_m_done, i_s_done,
    input  o_m_start, o_s_start, o_frame_valid, o_frame_sub, o_frame_cnt,
           o_m_overrun, o_timeout, o_state
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Periodic main/sub ADC conversion scheduler with frame completion flag and sticky error flags.
// Latency: tick -> o_m_start +1 clk; accepted done -> o_s_start or o_frame_valid +1 clk.
// Backpressure: none; ticks arriving while a frame is in flight are dropped and flagged as overrun.
module adc_sample_scheduler #(
  parameter int unsigned TIMEOUT_CYC = 2000,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  adc_sample_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    M_RUN = 2'd1,
    S_RUN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  state_t              state;
  state_t              state_nxt;

  logic [31:0]         per_cnt;
  logic [31:0]         per_len;
  logic [31:0]         cyc_clamp;
  logic                per_wrap;
  logic                tick;

  logic [7:0]          sub_cnt;
  logic                sub_due_now;
  logic                sub_due_q;

  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_hit;

  logic                m_start_q;
  logic                s_start_q;
  logic                overrun_q;
  logic                timeout_q;
  logic [FCNT_W-1:0]   frame_cnt_q;

  logic                m_start_nxt;
  logic                s_start_nxt;
  logic                take_tick;
  logic                set_overrun;
  logic                set_timeout;
  logic                enter_done;

  // Periods shorter than 2 cycles cannot be honoured, so they collapse to 2.
  assign cyc_clamp = (bus.i_m_cyc_t < 32'd2) ? 32'd2 : bus.i_m_cyc_t;
  assign per_wrap  = (per_cnt == per_len - 32'd1);
  assign tick      = bus.i_en && (per_cnt == 32'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      per_cnt <= 32'd0;
      per_len <= cyc_clamp;
    end else if (!bus.i_en) begin
      per_cnt <= 32'd0;
      per_len <= cyc_clamp;
    end else if (per_wrap) begin
      per_cnt <= 32'd0;
      per_len <= cyc_clamp;
    end else begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  assign sub_due_now = (bus.i_s_ratio != 8'd0) && (sub_cnt == bus.i_s_ratio - 8'd1);
  assign wait_hit    = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt   = state;
    m_start_nxt = 1'b0;
    s_start_nxt = 1'b0;
    take_tick   = 1'b0;
    set_timeout = 1'b0;
    enter_done  = 1'b0;
    set_overrun = tick && (state != IDLE);
    case (state)
      IDLE: begin
        if (tick) begin
          take_tick   = 1'b1;
          m_start_nxt = 1'b1;
          state_nxt   = M_RUN;
        end
      end
      M_RUN: begin
        // A done in the same cycle as its start pulse cannot belong to it.
        if (!m_start_q && bus.i_m_done) begin
          if (sub_due_q) begin
            s_start_nxt = 1'b1;
            state_nxt   = S_RUN;
          end else begin
            enter_done  = 1'b1;
            state_nxt   = DONE;
          end
        end else if (wait_hit) begin
          set_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      S_RUN: begin
        if (!s_start_q && bus.i_s_done) begin
          enter_done = 1'b1;
          state_nxt  = DONE;
        end else if (wait_hit) begin
          set_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if ((state_nxt != state) || (state == IDLE) || (state == DONE)) begin
      wait_cnt <= '0;
    end else if (!wait_hit) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sub_cnt   <= 8'd0;
      sub_due_q <= 1'b0;
    end else if (take_tick) begin
      sub_due_q <= sub_due_now;
      sub_cnt   <= sub_due_now ? 8'd0 : sub_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_start_q   <= 1'b0;
      s_start_q   <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      m_start_q <= m_start_nxt;
      s_start_q <= s_start_nxt;
      // New error events take priority over a simultaneous clear.
      if (set_overrun) begin
        overrun_q <= 1'b1;
      end else if (bus.i_clr_err) begin
        overrun_q <= 1'b0;
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end else if (bus.i_clr_err) begin
        timeout_q <= 1'b0;
      end
      if (enter_done) begin
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
    end
  end

  assign bus.o_m_start     = m_start_q;
  assign bus.o_s_start     = s_start_q;
  assign bus.o_frame_valid = (state == DONE);
  assign bus.o_frame_sub   = (state == DONE) && sub_due_q;
  assign bus.o_frame_cnt   = frame_cnt_q;
  assign bus.o_m_overrun   = overrun_q;
  assign bus.o_timeout     = timeout_q;
  assign bus.o_state       = state;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler: expected start/frame cycles are queued as stimulus
// is applied and matched against DUT pulses by a monitor; ADC done pulses come from a responder.
module tb_adc_sample_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int   m_dly = 0;
  int   s_dly = 0;
  int   m_at = -1;
  int   s_at = -1;
  bit   man_s_done = 1'b0;

  int   exp_m[$];
  int   exp_s[$];
  int   exp_f[$];
  bit   exp_fs[$];

  adc_sample_scheduler_if #(.FCNT_W(8)) bif();

  adc_sample_scheduler #(
    .TIMEOUT_CYC(2000),
    .FCNT_W(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: done pulses a fixed number of cycles after each observed start.
  always @(negedge clk) begin
    bif.i_m_done = (cyc == m_at);
    bif.i_s_done = (cyc == s_at) || man_s_done;
    if (bif.o_m_start && m_dly > 0) m_at = cyc + m_dly;
    if (bif.o_s_start && s_dly > 0) s_at = cyc + s_dly;
  end

  always @(negedge clk) begin
    int e;
    bit es;
    if (bif.o_m_start) begin
      total++;
      if (exp_m.size() == 0) begin
        bad++;
        $display("FAIL m_start: pulse at cycle %0d, required none", cyc);
      end else begin
        e = exp_m.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL m_start: pulse at cycle %0d, required %0d", cyc, e);
        end
      end
    end
    if (bif.o_s_start) begin
      total++;
      if (exp_s.size() == 0) begin
        bad++;
        $display("FAIL s_start: pulse at cycle %0d, required none", cyc);
      end else begin
        e = exp_s.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL s_start: pulse at cycle %0d, required %0d", cyc, e);
        end
      end
    end
    if (bif.o_frame_valid) begin
      total++;
      if (exp_f.size() == 0) begin
        bad++;
        $display("FAIL frame_valid: pulse at cycle %0d, required none", cyc);
      end else begin
        e  = exp_f.pop_front();
        es = exp_fs.pop_front();
        if (cyc !== e || bif.o_frame_sub !== es) begin
          bad++;
          $display("FAIL frame_valid: cycle %0d sub %0b, required cycle %0d sub %0b",
                   cyc, bif.o_frame_sub, e, es);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bif.i_en       = 1'b0;
    bif.i_m_cyc_t  = 32'd0;
    bif.i_s_ratio  = 8'd0;
    bif.i_clr_err  = 1'b0;
    man_s_done     = 1'b0;
    m_dly          = 0;
    s_dly          = 0;
    m_at           = -1;
    s_at           = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int r;
    rst           = 1'b1;
    bif.i_en      = 1'b1;
    bif.i_m_cyc_t = 32'd10;
    bif.i_s_ratio = 8'd0;
    bif.i_clr_err = 1'b0;
    m_dly         = 2;
    repeat (3) @(negedge clk);
    total++;
    if ({bif.o_m_start, bif.o_s_start, bif.o_frame_valid, bif.o_frame_sub,
         bif.o_m_overrun, bif.o_timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b, required 000000", {bif.o_m_start, bif.o_s_start,
               bif.o_frame_valid, bif.o_frame_sub, bif.o_m_overrun, bif.o_timeout});
    end
    total++;
    if (bif.o_frame_cnt !== 8'd0 || bif.o_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_cnt_state: cnt %0d state %0d, required 0 0", bif.o_frame_cnt, bif.o_state);
    end
    // First tick lands on the first cycle enable is seen after reset.
    r = cyc;
    exp_m.push_back(r + 1);
    exp_f.push_back(r + 4);
    exp_fs.push_back(1'b0);
    rst = 1'b0;
    wait_cyc(r + 5);
    bif.i_en = 1'b0;
    wait_cyc(r + 15);
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL reset_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
    total++;
    if (bif.o_frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL reset_first_frame_cnt: got %0d, required 1", bif.o_frame_cnt);
    end
  endtask

  task automatic test_main_only();
    int e;
    do_reset();
    bif.i_m_cyc_t = 32'd100;
    m_dly = 10;
    @(negedge clk);
    e = cyc;
    for (int k = 0; k < 5; k++) begin
      exp_m.push_back(e + 1 + 100 * k);
      exp_f.push_back(e + 12 + 100 * k);
      exp_fs.push_back(1'b0);
    end
    bif.i_en = 1'b1;
    wait_cyc(e + 420);
    bif.i_en = 1'b0;
    wait_cyc(e + 430);
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL main_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
    total++;
    if (bif.o_frame_cnt !== 8'd5 || bif.o_m_overrun !== 1'b0 || bif.o_timeout !== 1'b0) begin
      bad++;
      $display("FAIL main_status: cnt %0d ovr %0b to %0b, required 5 0 0",
               bif.o_frame_cnt, bif.o_m_overrun, bif.o_timeout);
    end
  endtask

  task automatic test_sub_ratio();
    int e;
    int st;
    do_reset();
    bif.i_m_cyc_t = 32'd100;
    bif.i_s_ratio = 8'd4;
    m_dly = 10;
    s_dly = 7;
    @(negedge clk);
    e = cyc;
    for (int k = 1; k <= 8; k++) begin
      st = e + 1 + 100 * (k - 1);
      exp_m.push_back(st);
      if (k % 4 == 0) begin
        exp_s.push_back(st + 11);
        exp_f.push_back(st + 19);
        exp_fs.push_back(1'b1);
      end else begin
        exp_f.push_back(st + 11);
        exp_fs.push_back(1'b0);
      end
    end
    bif.i_en = 1'b1;
    wait_cyc(e + 726);
    bif.i_en = 1'b0;
    wait_cyc(e + 740);
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL sub_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
    total++;
    if (bif.o_frame_cnt !== 8'd8) begin
      bad++;
      $display("FAIL sub_frame_cnt: got %0d, required 8", bif.o_frame_cnt);
    end
  endtask

  task automatic test_overrun();
    int e;
    int e2;
    do_reset();
    bif.i_m_cyc_t = 32'd20;
    m_dly = 30;
    @(negedge clk);
    e = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_m.push_back(e + 1 + 40 * k);
      exp_f.push_back(e + 32 + 40 * k);
      exp_fs.push_back(1'b0);
    end
    bif.i_en = 1'b1;
    wait_cyc(e + 20);
    total++;
    if (bif.o_m_overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_before_tick: got %0b, required 0", bif.o_m_overrun);
    end
    wait_cyc(e + 21);
    total++;
    if (bif.o_m_overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got %0b, required 1", bif.o_m_overrun);
    end
    wait_cyc(e + 115);
    bif.i_en = 1'b0;
    wait_cyc(e + 116);
    bif.i_clr_err = 1'b1;
    wait_cyc(e + 117);
    bif.i_clr_err = 1'b0;
    wait_cyc(e + 118);
    total++;
    if (bif.o_m_overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: got %0b, required 0", bif.o_m_overrun);
    end
    e2 = e + 120;
    wait_cyc(e2);
    exp_m.push_back(e2 + 1);
    exp_f.push_back(e2 + 32);
    exp_fs.push_back(1'b0);
    bif.i_en = 1'b1;
    wait_cyc(e2 + 20);
    bif.i_clr_err = 1'b1;
    wait_cyc(e2 + 21);
    bif.i_clr_err = 1'b0;
    total++;
    if (bif.o_m_overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set_beats_clear: got %0b, required 1", bif.o_m_overrun);
    end
    wait_cyc(e2 + 35);
    bif.i_en = 1'b0;
    wait_cyc(e2 + 45);
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL overrun_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
  endtask

  task automatic test_timeout();
    int e;
    do_reset();
    bif.i_m_cyc_t = 32'd5000;
    m_dly = 0;
    @(negedge clk);
    e = cyc;
    exp_m.push_back(e + 1);
    bif.i_en = 1'b1;
    wait_cyc(e + 2000);
    total++;
    if (bif.o_timeout !== 1'b0 || bif.o_state !== 2'd1) begin
      bad++;
      $display("FAIL timeout_early: to %0b state %0d, required 0 1", bif.o_timeout, bif.o_state);
    end
    wait_cyc(e + 2001);
    total++;
    if (bif.o_timeout !== 1'b1 || bif.o_state !== 2'd0 || bif.o_frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL timeout_set: to %0b state %0d cnt %0d, required 1 0 0",
               bif.o_timeout, bif.o_state, bif.o_frame_cnt);
    end
    wait_cyc(e + 2005);
    bif.i_clr_err = 1'b1;
    wait_cyc(e + 2006);
    bif.i_clr_err = 1'b0;
    wait_cyc(e + 2007);
    total++;
    if (bif.o_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got %0b, required 0", bif.o_timeout);
    end
    m_dly = 10;
    exp_m.push_back(e + 5001);
    exp_f.push_back(e + 5012);
    exp_fs.push_back(1'b0);
    wait_cyc(e + 5020);
    bif.i_en = 1'b0;
    wait_cyc(e + 5025);
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL timeout_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
    total++;
    if (bif.o_frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL timeout_frame_cnt: got %0d, required 1", bif.o_frame_cnt);
    end
  endtask

  task automatic test_period_clamp();
    int e;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      bif.i_m_cyc_t = v;
      m_dly = 2;
      @(negedge clk);
      e = cyc;
      // Ticks every 2 clk; a 4-cycle frame drops two of them, so starts land 6 clk apart.
      for (int k = 0; k < 3; k++) begin
        exp_m.push_back(e + 1 + 6 * k);
        exp_f.push_back(e + 4 + 6 * k);
        exp_fs.push_back(1'b0);
      end
      bif.i_en = 1'b1;
      wait_cyc(e + 17);
      bif.i_en = 1'b0;
      wait_cyc(e + 25);
      total++;
      if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
        bad++;
        $display("FAIL clamp_drain_p%0d: %0d events outstanding, required 0", v, exp_m.size() + exp_s.size() + exp_f.size());
        exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
      end
      total++;
      if (bif.o_m_overrun !== 1'b1 || bif.o_frame_cnt !== 8'd3) begin
        bad++;
        $display("FAIL clamp_status_p%0d: ovr %0b cnt %0d, required 1 3", v, bif.o_m_overrun, bif.o_frame_cnt);
      end
    end
  endtask

  task automatic test_period_change();
    int e;
    do_reset();
    bif.i_m_cyc_t = 32'd100;
    m_dly = 10;
    @(negedge clk);
    e = cyc;
    exp_m.push_back(e + 1);
    exp_m.push_back(e + 101);
    exp_m.push_back(e + 151);
    exp_m.push_back(e + 201);
    foreach (exp_m[i]) begin
      exp_f.push_back(exp_m[i] + 11);
      exp_fs.push_back(1'b0);
    end
    bif.i_en = 1'b1;
    wait_cyc(e + 50);
    bif.i_m_cyc_t = 32'd50;
    wait_cyc(e + 215);
    bif.i_en = 1'b0;
    wait_cyc(e + 230);
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL period_change_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    int e;
    do_reset();
    bif.i_m_cyc_t = 32'd100;
    bif.i_s_ratio = 8'd1;
    m_dly = 5;
    s_dly = 0;
    @(negedge clk);
    e = cyc;
    exp_m.push_back(e + 1);
    exp_s.push_back(e + 7);
    bif.i_en = 1'b1;
    wait_cyc(e + 9);
    total++;
    if (bif.o_state !== 2'd2) begin
      bad++;
      $display("FAIL midrst_in_s_run: state %0d, required 2", bif.o_state);
    end
    wait_cyc(e + 10);
    rst = 1'b1;
    bif.i_en = 1'b0;
    wait_cyc(e + 11);
    total++;
    if ({bif.o_m_start, bif.o_s_start, bif.o_frame_valid, bif.o_frame_sub, bif.o_m_overrun,
         bif.o_timeout, bif.o_state, bif.o_frame_cnt} !== 16'd0) begin
      bad++;
      $display("FAIL midrst_outputs: state %0d cnt %0d fv %0b, required all 0",
               bif.o_state, bif.o_frame_cnt, bif.o_frame_valid);
    end
    wait_cyc(e + 12);
    rst = 1'b0;
    man_s_done = 1'b1;
    wait_cyc(e + 13);
    man_s_done = 1'b0;
    wait_cyc(e + 20);
    total++;
    if (bif.o_state !== 2'd0 || bif.o_frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL midrst_late_done: state %0d cnt %0d, required 0 0", bif.o_state, bif.o_frame_cnt);
    end
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL midrst_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
  endtask

  task automatic test_back_to_back_wrap();
    int e;
    do_reset();
    bif.i_m_cyc_t = 32'd4;
    m_dly = 1;
    @(negedge clk);
    e = cyc;
    for (int k = 0; k < 256; k++) begin
      exp_m.push_back(e + 1 + 4 * k);
      exp_f.push_back(e + 3 + 4 * k);
      exp_fs.push_back(1'b0);
    end
    bif.i_en = 1'b1;
    wait_cyc(e + 1020);
    total++;
    if (bif.o_frame_cnt !== 8'd255) begin
      bad++;
      $display("FAIL wrap_pre: frame_cnt %0d, required 255", bif.o_frame_cnt);
    end
    wait_cyc(e + 1022);
    bif.i_en = 1'b0;
    wait_cyc(e + 1030);
    total++;
    if (bif.o_frame_cnt !== 8'd0 || bif.o_m_overrun !== 1'b0) begin
      bad++;
      $display("FAIL wrap_post: frame_cnt %0d ovr %0b, required 0 0", bif.o_frame_cnt, bif.o_m_overrun);
    end
    total++;
    if (exp_m.size() + exp_s.size() + exp_f.size() !== 0) begin
      bad++;
      $display("FAIL wrap_drain: %0d events outstanding, required 0", exp_m.size() + exp_s.size() + exp_f.size());
      exp_m.delete(); exp_s.delete(); exp_f.delete(); exp_fs.delete();
    end
  endtask

  initial begin
    bif.i_en      = 1'b0;
    bif.i_m_cyc_t = 32'd0;
    bif.i_s_ratio = 8'd0;
    bif.i_clr_err = 1'b0;
    bif.i_m_done  = 1'b0;
    bif.i_s_done  = 1'b0;
    @(negedge clk);
    test_reset();
    test_main_only();
    test_sub_ratio();
    test_overrun();
    test_timeout();
    test_period_clamp();
    test_period_change();
    test_reset_mid_frame();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
